// File: rtl/spi_stepper_master_if.sv
// Bundles the handshake, byte-source and SPI pins of spi_stepper_master.
//   master : the SPI master (drives SSEL/SCK/MOSI, status, tx_idx, rx_*)
//   slave  : the user side (drives start/abort/tx_byte, and MISO on the wire)
interface spi_stepper_master_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [4:0] tx_idx;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic [4:0] rx_idx;
  logic       rx_valid;
  logic       SSEL;
  logic       SCK;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, abort, tx_byte, MISO,
    output busy, done, aborted, tx_idx, rx_byte, rx_idx, rx_valid,
           SSEL, SCK, MOSI
  );

  modport slave (
    output start, abort, tx_byte, MISO,
    input  busy, done, aborted, tx_idx, rx_byte, rx_idx, rx_valid,
           SSEL, SCK, MOSI
  );
endinterface

// File: rtl/spi_stepper_master.sv
// SPI mode-0 master for the stepper frame protocol: one fixed-length frame of
// NBYTES bytes (MSB first) per start request, SCK half-period DIV clk cycles,
// CSGAP half-periods of SSEL setup and hold.
// Ports:
//   clk     system clock
//   nRESET  synchronous active-low reset
//   bus     spi_stepper_master_if.master: start/abort/busy/done/aborted,
//           tx_idx/tx_byte byte source, rx_byte/rx_idx/rx_valid result,
//           SSEL/SCK/MOSI/MISO pins
module spi_stepper_master #(
  parameter int unsigned NBYTES = 20,
  parameter int unsigned DIV    = 8,
  parameter int unsigned CSGAP  = 2
) (
  input  logic                        clk,
  input  logic                        nRESET,
  spi_stepper_master_if.master        bus
);

  localparam int unsigned DW = $clog2(DIV);
  localparam int unsigned GW = (CSGAP > 1) ? $clog2(CSGAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CSGAP - 1);
  localparam logic [4:0]    IDX_LAST = 5'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [GW-1:0] r_gap;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          r_load;
  logic          r_ssel, r_sck, r_mosi;
  logic          r_busy, r_done, r_aborted, r_rx_valid;
  logic [4:0]    r_tx_idx, r_rx_idx;
  logic [7:0]    r_rx_byte;
  logic          w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_gap      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_load     <= 1'b0;
      r_ssel     <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_idx   <= '0;
      r_rx_idx   <= '0;
      r_rx_byte  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
      if (r_state != S_IDLE)
        r_div <= w_tick ? '0 : r_div + 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_SETUP;
            r_busy    <= 1'b1;
            r_ssel    <= 1'b0;
            r_aborted <= 1'b0;
            r_tx_idx  <= '0;
            r_tx      <= bus.tx_byte;
            r_mosi    <= bus.tx_byte[7];
            r_bit     <= '0;
            r_gap     <= '0;
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            if (r_gap == GAP_LAST) begin
              r_gap   <= '0;
              r_sck   <= 1'b1;
              r_state <= S_HIGH;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            r_sck <= 1'b0;
            r_rx  <= {r_rx[6:0], bus.MISO};
            r_bit <= r_bit + 1'b1;
            if (r_bit != 3'd7) begin
              r_tx    <= {r_tx[6:0], 1'b0};
              r_mosi  <= r_tx[6];
              r_state <= S_LOW;
            end else begin
              r_rx_byte  <= {r_rx[6:0], bus.MISO};
              r_rx_idx   <= r_tx_idx;
              r_rx_valid <= 1'b1;
              if (r_tx_idx == IDX_LAST) begin
                r_gap   <= '0;
                r_state <= S_HOLD;
              end else begin
                // tx_byte is combinational on tx_idx, so the new byte is
                // picked up one cycle after the index advances.
                r_tx_idx <= r_tx_idx + 5'd1;
                r_load   <= 1'b1;
                r_state  <= S_LOW;
              end
            end
          end
        end
        S_LOW: begin
          if (r_load) begin
            r_load <= 1'b0;
            r_tx   <= bus.tx_byte;
            r_mosi <= bus.tx_byte[7];
          end
          if (w_tick) begin
            r_sck   <= 1'b1;
            r_state <= S_HIGH;
          end
        end
        S_HOLD: begin
          r_sck <= 1'b0;
          if (w_tick) begin
            if (r_gap == GAP_LAST) begin
              r_ssel  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_div    <= '0;
          r_tx_idx <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort overrides the state transition above but leaves a coinciding
      // byte-complete strobe intact.
      if (bus.abort && (r_state == S_SETUP || r_state == S_HIGH || r_state == S_LOW)) begin
        r_state   <= S_HOLD;
        r_sck     <= 1'b0;
        r_aborted <= 1'b1;
        r_gap     <= '0;
        r_load    <= 1'b0;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.aborted  = r_aborted;
  assign bus.tx_idx   = r_tx_idx;
  assign bus.rx_byte  = r_rx_byte;
  assign bus.rx_idx   = r_rx_idx;
  assign bus.rx_valid = r_rx_valid;
  assign bus.SSEL     = r_ssel;
  assign bus.SCK      = r_sck;
  assign bus.MOSI     = r_mosi;

endmodule
